// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state, access-kind encoding and NOP constant for the fetch/memory stage
package fetch_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {FETCH, LOAD, STORE} kind_t;
  localparam logic [31:0] NOP_INST = 32'hE1A00000;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: BUSY-cycle counter that flags expiry on the TIMEOUT_CYCLES-th cycle without an ack
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // count enabled cycles, restart whenever the access is not outstanding
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: PC/IR/load-data registers and req/ack memory port; macro FETCH_TIMEOUT_EN enables the BUSY watchdog
module fetch_mem_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              ir_write,
  input  logic              adr_src,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] result,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] pc,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);
  state_t state;
  kind_t  kind;
  logic   cmd, done;
  assign cmd = ir_write | adr_src;
`ifdef FETCH_TIMEOUT_EN
  logic expired;
  fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk(clk), .reset(reset), .clr(state == IDLE), .en(state == BUSY), .expired(expired)
  );
  assign done = mem_ack | expired;
`else
  assign done = mem_ack;
  assign bus_err = 1'b0;
`endif
  assign stall = (state == IDLE) ? cmd : ~done;
  // launch on a command in IDLE, retire on ack (or watchdog expiry), update PC when not stalled
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      kind      <= FETCH;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pc        <= RESET_PC;
      inst      <= '0;
      data_out  <= '0;
`ifdef FETCH_TIMEOUT_EN
      bus_err   <= 1'b0;
`endif
    end else begin
      if (pc_write && !stall) pc <= ADDR_W'(result);
      if (state == IDLE) begin
        if (cmd) begin
          state     <= BUSY;
          mem_req   <= 1'b1;
          kind      <= ir_write ? FETCH : (mem_write ? STORE : LOAD);
          mem_addr  <= ir_write ? pc : alu_out;
          mem_we    <= !ir_write && mem_write;
          mem_wdata <= write_data;
        end
      end else if (mem_ack) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (kind == FETCH) inst <= mem_rdata;
        if (kind == LOAD) data_out <= mem_rdata;
`ifdef FETCH_TIMEOUT_EN
      end else if (expired) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        bus_err <= 1'b1;
        if (kind == FETCH) inst <= DATA_W'(NOP_INST);
        if (kind == LOAD) data_out <= '0;
`endif
      end
    end
endmodule
